// File: rtl/mem_dbus_access_pkg.sv
// Shared encodings for the MEM-stage data-bus access block: ALU op codes,
// exception codes, bus size encodings and the 3-bit FSM state type.
package mem_dbus_access_pkg;

  localparam logic [7:0] ALUOP_NOP  = 8'h00;
  localparam logic [7:0] ALUOP_ADDU = 8'h19;
  localparam logic [7:0] ALUOP_LB   = 8'h90;
  localparam logic [7:0] ALUOP_LBU  = 8'h91;
  localparam logic [7:0] ALUOP_LH   = 8'h92;
  localparam logic [7:0] ALUOP_LHU  = 8'h93;
  localparam logic [7:0] ALUOP_LW   = 8'h94;
  localparam logic [7:0] ALUOP_SB   = 8'h98;
  localparam logic [7:0] ALUOP_SH   = 8'h99;
  localparam logic [7:0] ALUOP_SW   = 8'h9A;

  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StDone  = 3'd3,
    StDrain = 3'd4
  } state_e;

  function automatic logic is_store(input logic [7:0] op);
    return op inside {ALUOP_SB, ALUOP_SH, ALUOP_SW};
  endfunction

  function automatic logic is_access(input logic [7:0] op);
    return is_store(op) || (op inside {ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW});
  endfunction

  function automatic logic [1:0] op_size(input logic [7:0] op);
    logic [1:0] size;
    size = SIZE_BYTE;
    if (op inside {ALUOP_LH, ALUOP_LHU, ALUOP_SH}) size = SIZE_HALF;
    if (op inside {ALUOP_LW, ALUOP_SW})            size = SIZE_WORD;
    return size;
  endfunction

endpackage

// File: rtl/mem_dbus_access_lane.sv
// Combinational byte-lane helper: store strobe/replication and load
// lane selection with sign or zero extension.
module mem_lane_ext
  import mem_dbus_access_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] din,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wstrb    = 4'b0000;
    wdata    = 32'h0;
    load_ext = 32'h0;
    case (op)
      ALUOP_SB: begin
        wstrb = 4'b0001 << lane;
        wdata = {4{din[7:0]}};
      end
      ALUOP_SH: begin
        wstrb = 4'b0011 << lane;
        wdata = {2{din[15:0]}};
      end
      ALUOP_SW: begin
        wstrb = 4'hF;
        wdata = din;
      end
      ALUOP_LB:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      ALUOP_LBU: load_ext = {24'h0, byte_sel};
      ALUOP_LH:  load_ext = {{16{half_sel[15]}}, half_sel};
      ALUOP_LHU: load_ext = {16'h0, half_sel};
      ALUOP_LW:  load_ext = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_dbus_access.sv
// MEM-stage data-bus access FSM. Optional alignment trapping is enabled by
// defining MEM_ALIGN_CHECK_EN; otherwise misaligned addresses are force-aligned.
module mem_dbus_access
  import mem_dbus_access_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter logic [31:0] UNMAPPED_MASK = 32'h1FFF_FFFF
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic [7:0]        mem_aluop,
  input  logic [31:0]       mem_wd,
  input  logic [31:0]       mem_din,
  input  logic [4:0]        mem_exccode,
  input  logic              flush,
  input  logic              mem_adv,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       load_data,
  output logic              stallreq_mem,
  output logic [4:0]        exccode_o
);

  state_e      state_q, state_d;
  logic [31:0] ld_q, ld_d;
  logic        req, stall;
  logic        access_op, store, clean, access_cond;
  logic [1:0]  size;
  logic [31:0] addr_aligned, addr_phys;
  logic [4:0]  align_exc;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata, lane_load;

  assign access_op = is_access(mem_aluop);
  assign store     = is_store(mem_aluop);
  assign size      = op_size(mem_aluop);
  assign clean     = (mem_exccode == EXC_NONE);

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = ((size == SIZE_HALF) && mem_wd[0]) ||
                    ((size == SIZE_WORD) && (mem_wd[1:0] != 2'b00));
  assign access_cond  = access_op && clean && !flush && !misalign;
  assign align_exc    = (access_op && misalign) ? (store ? EXC_ADES : EXC_ADEL) : EXC_NONE;
  assign addr_aligned = mem_wd;
`else
  assign access_cond  = access_op && clean && !flush;
  assign align_exc    = EXC_NONE;
  always_comb begin
    addr_aligned = mem_wd;
    if (size == SIZE_HALF) addr_aligned[0]   = 1'b0;
    if (size == SIZE_WORD) addr_aligned[1:0] = 2'b00;
  end
`endif

  assign addr_phys = addr_aligned & UNMAPPED_MASK;

  mem_lane_ext u_lane (
    .op       (mem_aluop),
    .lane     (addr_aligned[1:0]),
    .din      (mem_din),
    .rdata    (data_rdata),
    .wstrb    (lane_wstrb),
    .wdata    (lane_wdata),
    .load_ext (lane_load)
  );

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      // The slave may accept in the same cycle the request first appears.
      StIdle, StReq: begin
        if (state_q == StReq || access_cond) begin
          req     = 1'b1;
          stall   = 1'b1;
          state_d = StReq;
          if (data_addr_ok) begin
            if (data_data_ok) begin
              state_d = flush ? StIdle : StDone;
              ld_d    = lane_load;
            end else begin
              state_d = flush ? StDrain : StWait;
            end
          end else if (flush) begin
            state_d = StIdle;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        if (data_data_ok) begin
          state_d = flush ? StIdle : StDone;
          ld_d    = lane_load;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDone: begin
        if (mem_adv || flush) state_d = StIdle;
      end
      StDrain: begin
        stall = access_cond;
        if (data_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset is active-high despite the port name.
    if (cpu_rst_n) begin
      req     = 1'b0;
      stall   = 1'b0;
      state_d = StIdle;
      ld_d    = 32'h0;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n) begin
      state_q <= StIdle;
      ld_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
    end
  end

  assign data_req     = req;
  assign data_wr      = req & store;
  assign data_size    = req ? size : SIZE_BYTE;
  assign data_wstrb   = req ? lane_wstrb : 4'b0000;
  assign data_wdata   = req ? lane_wdata : 32'h0;
  assign data_addr    = req ? addr_phys[ADDR_W-1:0] : '0;
  assign stallreq_mem = stall;
  assign load_data    = (!cpu_rst_n && state_q == StDone) ? ld_q : 32'h0;
  assign exccode_o    = cpu_rst_n ? EXC_NONE : (clean ? align_exc : mem_exccode);

endmodule

// File: tb/tb_mem_dbus_access.sv
// Self-checking bench for mem_dbus_access: directed scenarios plus randomized
// accesses checked against an arithmetic reference model.
module tb_mem_dbus_access;
  import mem_dbus_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] wd, din, rdata;
  logic [4:0]  exccode;
  logic        flush, mem_adv, addr_ok, data_ok;
  logic        data_req, data_wr, stallreq_mem;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, load_data;
  logic [4:0]  exccode_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_dbus_access dut (
    .cpu_clk_50M  (clk),
    .cpu_rst_n    (rst),
    .mem_aluop    (aluop),
    .mem_wd       (wd),
    .mem_din      (din),
    .mem_exccode  (exccode),
    .flush        (flush),
    .mem_adv      (mem_adv),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (addr_ok),
    .data_data_ok (data_ok),
    .data_rdata   (rdata),
    .load_data    (load_data),
    .stallreq_mem (stallreq_mem),
    .exccode_o    (exccode_o)
  );

  // Reference model: derived from access width and byte offset arithmetic.
  function automatic int unsigned nbytes(input logic [7:0] op);
    if (op == ALUOP_LB || op == ALUOP_LBU || op == ALUOP_SB) return 1;
    if (op == ALUOP_LH || op == ALUOP_LHU || op == ALUOP_SH) return 2;
    return 4;
  endfunction

  function automatic logic m_store(input logic [7:0] op);
    return (op == ALUOP_SB || op == ALUOP_SH || op == ALUOP_SW);
  endfunction

  function automatic logic [31:0] m_addr(input logic [7:0] op, input logic [31:0] a);
    return (a - (a % nbytes(op))) & 32'h1FFF_FFFF;
  endfunction

  function automatic logic [31:0] m_wstrb(input logic [7:0] op, input logic [31:0] a);
    int unsigned n, off;
    n   = nbytes(op);
    off = m_addr(op, a) % 4;
    if (!m_store(op)) return 32'h0;
    return (((32'h1 << n) - 1) << off) & 32'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] d);
    if (nbytes(op) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (nbytes(op) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] v;
    v = r >> (8 * (m_addr(op, a) % 4));
    if (nbytes(op) == 1) begin
      v = v & 32'hFF;
      if (op == ALUOP_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (nbytes(op) == 2) begin
      v = v & 32'hFFFF;
      if (op == ALUOP_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag, input logic req_e, input logic stall_e);
    @(negedge clk);
    check({tag, "_req"}, 32'(data_req), 32'(req_e));
    check({tag, "_stall"}, 32'(stallreq_mem), 32'(stall_e));
    tick();
  endtask

  // addr_ok arrives in cycle a_cyc, data_ok in cycle d_cyc (d_cyc >= a_cyc >= 1).
  task automatic run_access(input string tag, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rd,
                            input int a_cyc, input int d_cyc);
    int stall_cycles;
    stall_cycles = 0;
    aluop = op; wd = a; din = d; exccode = EXC_NONE; flush = 1'b0;
    for (int k = 0; k <= d_cyc + 1; k++) begin
      addr_ok = (k == a_cyc);
      data_ok = (k == d_cyc);
      rdata   = (k == d_cyc) ? rd : $urandom;
      mem_adv = (k == d_cyc + 1);
      @(negedge clk);
      if (stallreq_mem) stall_cycles++;
      if (k <= a_cyc) begin
        check({tag, "_req"}, 32'(data_req), 32'd1);
        check({tag, "_addr"}, data_addr, m_addr(op, a));
        check({tag, "_size"}, 32'(data_size), 32'($clog2(nbytes(op))));
        check({tag, "_wr"}, 32'(data_wr), 32'(m_store(op)));
        check({tag, "_wstrb"}, 32'(data_wstrb), m_wstrb(op, a));
        if (m_store(op)) check({tag, "_wdata"}, data_wdata, m_wdata(op, d));
      end else begin
        check({tag, "_req_off"}, 32'(data_req), 32'd0);
      end
      if (k == 0) check({tag, "_exc"}, 32'(exccode_o), 32'(EXC_NONE));
      if (k == d_cyc + 1 && !m_store(op)) check({tag, "_load"}, load_data, m_load(op, a, rd));
      tick();
    end
    check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(d_cyc + 1));
    addr_ok = 1'b0; data_ok = 1'b0; mem_adv = 1'b0; aluop = ALUOP_NOP;
  endtask

  logic [7:0] ops [8] = '{ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU,
                          ALUOP_LW, ALUOP_SB, ALUOP_SH, ALUOP_SW};

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; aluop = ALUOP_LW; wd = 32'h8000_0010; din = 32'h0; rdata = 32'h0;
    exccode = EXC_NONE; flush = 1'b0; mem_adv = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_stall", 32'(stallreq_mem), 32'd0);
    check("rst_exc", 32'(exccode_o), 32'(EXC_NONE));
    check("rst_load", load_data, 32'h0);
    check("rst_addr", data_addr, 32'h0);
    tick();
    rst = 1'b0; aluop = ALUOP_NOP;
    tick();

    run_access("lw", ALUOP_LW, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1, 2);
    run_access("lb", ALUOP_LB, 32'h8000_0203, 32'h0, 32'h8012_3456, 1, 2);
    run_access("lbu", ALUOP_LBU, 32'h8000_0203, 32'h0, 32'h8012_3456, 2, 3);
    run_access("sh", ALUOP_SH, 32'h8000_0302, 32'h1234_ABCD, 32'h0, 1, 1);
    run_access("lh_same", ALUOP_LH, 32'h8000_0402, 32'h0, 32'h9ABC_1234, 1, 1);

    // Flush while waiting for data: drain, hold a new LW off the bus, then issue it.
    aluop = ALUOP_LW; wd = 32'h8000_0040;
    step_check("drn_c0", 1'b1, 1'b1);
    addr_ok = 1'b1;
    step_check("drn_c1", 1'b1, 1'b1);
    addr_ok = 1'b0; flush = 1'b1;
    step_check("drn_flush", 1'b0, 1'b1);
    flush = 1'b0; wd = 32'h8000_0080;
    step_check("drn_hold0", 1'b0, 1'b1);
    step_check("drn_hold1", 1'b0, 1'b1);
    data_ok = 1'b1; rdata = $urandom;
    step_check("drn_ok", 1'b0, 1'b1);
    data_ok = 1'b0;
    run_access("drn_next", ALUOP_LW, 32'h8000_0080, 32'h0, 32'h0BAD_F00D, 1, 2);

    // Flush while the request is unaccepted abandons it.
    aluop = ALUOP_LW; wd = 32'h8000_0100;
    step_check("rqf_c0", 1'b1, 1'b1);
    flush = 1'b1;
    step_check("rqf_flush", 1'b1, 1'b1);
    flush = 1'b0; aluop = ALUOP_ADDU;
    step_check("rqf_idle", 1'b0, 1'b0);

    // Reset in the middle of a transaction.
    aluop = ALUOP_LW; wd = 32'h8000_0200;
    step_check("mrst_c0", 1'b1, 1'b1);
    addr_ok = 1'b1;
    step_check("mrst_c1", 1'b1, 1'b1);
    addr_ok = 1'b0; rst = 1'b1;
    step_check("mrst_rst", 1'b0, 1'b0);
    rst = 1'b0; aluop = ALUOP_ADDU;
    step_check("mrst_idle", 1'b0, 1'b0);

    // Upstream exception and non-access passthrough.
    aluop = ALUOP_LW; wd = 32'h8000_0010; exccode = 5'h0A;
    @(negedge clk);
    check("exc_req", 32'(data_req), 32'd0);
    check("exc_stall", 32'(stallreq_mem), 32'd0);
    check("exc_code", 32'(exccode_o), 32'h0A);
    check("exc_load", load_data, 32'h0);
    tick();
    exccode = EXC_NONE; aluop = ALUOP_ADDU;
    @(negedge clk);
    check("addu_req", 32'(data_req), 32'd0);
    check("addu_stall", 32'(stallreq_mem), 32'd0);
    check("addu_exc", 32'(exccode_o), 32'(EXC_NONE));
    tick();

`ifdef MEM_ALIGN_CHECK_EN
    aluop = ALUOP_LW; wd = 32'h8000_0101;
    @(negedge clk);
    check("mis_lw_exc", 32'(exccode_o), 32'(EXC_ADEL));
    check("mis_lw_req", 32'(data_req), 32'd0);
    check("mis_lw_stall", 32'(stallreq_mem), 32'd0);
    tick();
    aluop = ALUOP_SW;
    @(negedge clk);
    check("mis_sw_exc", 32'(exccode_o), 32'(EXC_ADES));
    check("mis_sw_req", 32'(data_req), 32'd0);
    tick();
    aluop = ALUOP_NOP;
`else
    run_access("mis_lw", ALUOP_LW, 32'h8000_0101, 32'h0, 32'h1357_9BDF, 1, 2);
    run_access("mis_sh", ALUOP_SH, 32'h8000_0107, 32'hCAFE_5A5A, 32'h0, 2, 2);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [7:0]  op;
      logic [31:0] a;
      int          ac, dc;
      op = ops[$urandom_range(7, 0)];
      a  = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      a = a - (a % nbytes(op));
`endif
      ac = $urandom_range(3, 1);
      dc = ac + $urandom_range(3, 0);
      run_access($sformatf("rnd%0d", i), op, a, $urandom, $urandom, ac, dc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dbus_access.md
Name: mem_dbus_access

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register: reads mem_aluop, mem_wd (effective address), mem_din (store data) and mem_exccode.
- Drives a handshaked data-bus request (req/addr_ok/data_ok) and returns byte-extended load data to the MEM/WB path.
- While an access is outstanding it raises stallreq_mem toward the stall controller, which holds the EXE/MEM register stable.

Parameters:
ADDR_W, 32, data-bus address width; low 2 bits select the byte lane
UNMAPPED_MASK, 32'h1FFF_FFFF, AND-mask applied to the virtual address to form data_addr

Ports:
cpu_clk_50M  in  1  core clock
cpu_rst_n  in  1  synchronous active-high reset
mem_aluop  in  8  ALU op; LB/LBU/LH/LHU/LW/SB/SH/SW are accesses, all others are non-access
mem_wd  in  32  effective address for loads/stores
mem_din  in  32  store data, right-aligned
mem_exccode  in  5  upstream exception code; EXC_NONE means clean
flush  in  1  pipeline flush
mem_adv  in  1  MEM/WB register captures this cycle (stall[4]==NOSTOP)
data_req  out  1  bus request
data_wr  out  1  1 = store
data_size  out  2  0 byte, 1 half, 2 word
data_wstrb  out  4  byte-lane write enables
data_addr  out  ADDR_W  bus address
data_wdata  out  32  lane-replicated store data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data valid / write done
data_rdata  in  32  bus read data
load_data  out  32  extended load result, valid in DONE
stallreq_mem  out  1  stall request
exccode_o  out  5  exception code forwarded to the exception unit

Behaviour:
- Reset values: all outputs 0; exccode_o = EXC_NONE; FSM in IDLE.
- The access condition is evaluated combinationally: access op, mem_exccode == EXC_NONE, flush == 0, and no misalignment.

FSM states and transitions:
- IDLE: if the access condition holds, go to REQ.
  - data_req asserts in that same cycle (combinational from IDLE).
  - stallreq_mem is 1.
- REQ: data_req = 1; data_addr, data_wdata, data_wstrb, data_size and data_wr are held stable.
  - On data_addr_ok, go to WAIT.
  - On flush with no addr_ok, go to IDLE; no transaction was issued.
- WAIT: stallreq_mem = 1.
  - On data_data_ok, capture data_rdata, perform the extension, go to DONE.
  - On flush without data_ok, go to DRAIN.
- DONE: stallreq_mem = 0; load_data is held.
  - On mem_adv or flush, go to IDLE.
- DRAIN: the transaction is orphaned.
  - Wait for data_data_ok, discard the data, go to IDLE.
  - stallreq_mem = 1 if a new access condition is present; no new request is issued until drained.

Byte lanes (addr[1:0] = a):
- SB: wstrb = 1<<a; wdata = {4{din[7:0]}}.
- SH: wstrb = 4'b0011 << a; wdata = {2{din[15:0]}}.
- SW: wstrb = 4'hF; wdata = din.
- Loads: wstrb = 0.

Load extension:
- LB/LBU select the byte at lane a; LH/LHU select the half at lane a[1].
- LB and LH sign-extend; LBU and LHU zero-extend.

Address: data_addr = mem_wd & UNMAPPED_MASK.

Exceptions and non-access ops:
- exccode_o = mem_exccode if it is not EXC_NONE, else the alignment code (see Optional Feature), else EXC_NONE.
- A non-access op or a pending exception passes straight through: no request, stallreq_mem = 0, load_data = 0.
- Back-to-back accesses: DONE→IDLE on mem_adv; the next instruction is evaluated in IDLE on the following cycle.
- Simultaneous data_addr_ok and data_data_ok in REQ: go directly to DONE with the captured data.
- Reset mid-transaction: FSM goes to IDLE; the bus side is reset together with the core.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned accesses are suppressed: LH/LHU/SH with a[0] != 0, and LW/SW with a != 0.
  - Loads report exccode_o = EXC_ADEL; stores report EXC_ADES.
  - No data_req is raised.
- Undefined:
  - The address is forced aligned by clearing its low bits per size.
  - No alignment exception is ever raised.

Decomposition:
- Shared defines include: ALUOP codes, EXC_NONE/EXC_ADEL/EXC_ADES, data_size encodings, and FSM state encodings (3-bit).
- One sub-module, mem_lane_ext: a combinational load-extension and store-replication helper.

Test Plan:
- LW at 0x8000_0010, addr_ok +1 cycle, data_ok +2 cycles, rdata 0xDEAD_BEEF.
  - Expect data_addr 0x0000_0010; stallreq high for 3 cycles; load_data 0xDEAD_BEEF in DONE.
- LB at addr 0x..03 with rdata 0x80xx_xxxx → load_data 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x..02 with din 0x1234_ABCD → wstrb 4'b1100, wdata 0xABCD_ABCD, data_size 1, data_wr 1.
- flush asserted in WAIT, data_ok 3 cycles later.
  - FSM goes to DRAIN; a new LW present during the drain holds stallreq=1 with no req.
  - After data_ok, the req issues.
- With MEM_ALIGN_CHECK_EN: LW at 0x..01 → exccode_o EXC_ADEL, data_req 0, stallreq 0.
  - Without the macro: the same case gives data_addr ending 0x..00.
- mem_exccode = 0x0A with LW → no req, exccode_o 0x0A. ADDU op → passthrough, stallreq 0.
